// File: rtl/frequency_result_writer.sv
// Sequencer that snapshots the frequency-analyzer results on a stop rising edge and
// writes them to consecutive registers with an ack handshake and a per-word timeout.
module frequency_result_writer #(
  parameter int REGISTERS_NUMBER      = 6,
  parameter int DATA_WIDTH            = 32,
  parameter int REGISTER_NUMBER_WIDTH = 8,
  parameter int ACK_TIMEOUT           = 255,
  parameter int IRQ_PULSE_LENGTH      = 4
) (
  input  logic                                 s00_axi_aclk,
  input  logic                                 s00_axi_aresetn,
  input  logic                                 stop,
  input  logic [REGISTERS_NUMBER*DATA_WIDTH-1:0] values,
  output logic [1:0]                           register_operation,
  output logic [REGISTER_NUMBER_WIDTH-1:0]     register_number,
  output logic [DATA_WIDTH-1:0]                register_write,
  input  logic                                 register_ack,
  output logic                                 busy,
  output logic                                 write_completed,
  output logic                                 irq,
  output logic                                 timeout_error,
  output logic [7:0]                           missed_count
);

  localparam int IDX_W  = (REGISTERS_NUMBER > 1) ? $clog2(REGISTERS_NUMBER) : 1;
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int IRQ_W  = $clog2(IRQ_PULSE_LENGTH + 1);

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FINISH,
    S_HOLD
  } state_t;

  state_t                           state, state_n;
  logic [IDX_W-1:0]                 idx, idx_n, idx_inc;
  logic [WAIT_W-1:0]                wait_cnt, wait_n;
  logic [IRQ_W-1:0]                 irq_cnt, irq_n;
  logic                             stop_d;
  logic                             rise;
  logic                             timeout;
  logic                             load;
  logic [1:0]                       op_n;
  logic [REGISTER_NUMBER_WIDTH-1:0] num_n;
  logic [DATA_WIDTH-1:0]            data_n;
  logic                             busy_n, wc_n, te_n;
  logic [7:0]                       missed_n;
  logic [DATA_WIDTH-1:0]            shadow [REGISTERS_NUMBER];

  assign rise    = stop & ~stop_d;
  assign idx_inc = idx + IDX_W'(1);
  assign irq     = (irq_cnt != '0);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
    state_n  = state;
    idx_n    = idx;
    wait_n   = wait_cnt;
    op_n     = register_operation;
    num_n    = register_number;
    data_n   = register_write;
    busy_n   = busy;
    wc_n     = write_completed;
    te_n     = timeout_error;
    missed_n = missed_count;
    irq_n    = (irq_cnt != '0) ? irq_cnt - IRQ_W'(1) : '0;
    load     = 1'b0;
    timeout  = 1'b0;

    if (rise && state != S_IDLE && missed_count != 8'hFF) begin
      missed_n = missed_count + 8'd1;
    end

    unique case (state)
      S_IDLE: begin
        if (rise) begin
          load    = 1'b1;
          wc_n    = 1'b0;
          te_n    = 1'b0;
          busy_n  = 1'b1;
          idx_n   = '0;
          wait_n  = '0;
          op_n    = OP_WRITE;
          num_n   = '0;
          data_n  = values[DATA_WIDTH-1:0];
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        timeout = !register_ack && (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));
        if (register_ack || timeout) begin
          wait_n = '0;
          if (timeout) te_n = 1'b1;
          if (idx == IDX_W'(REGISTERS_NUMBER - 1)) begin
            op_n    = OP_IDLE;
            num_n   = '0;
            data_n  = '0;
            busy_n  = 1'b0;
            wc_n    = 1'b1;
            irq_n   = IRQ_W'(IRQ_PULSE_LENGTH);
            state_n = S_FINISH;
          end else begin
            idx_n  = idx_inc;
            num_n  = REGISTER_NUMBER_WIDTH'(idx_inc);
            data_n = shadow[idx_inc];
          end
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      S_FINISH: state_n = S_HOLD;
      S_HOLD:   if (!stop) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state              <= S_IDLE;
      idx                <= '0;
      wait_cnt           <= '0;
      irq_cnt            <= '0;
      stop_d             <= 1'b1;
      register_operation <= OP_IDLE;
      register_number    <= '0;
      register_write     <= '0;
      busy               <= 1'b0;
      write_completed    <= 1'b0;
      timeout_error      <= 1'b0;
      missed_count       <= 8'd0;
    end else begin
      state              <= state_n;
      idx                <= idx_n;
      wait_cnt           <= wait_n;
      irq_cnt            <= irq_n;
      stop_d             <= stop;
      register_operation <= op_n;
      register_number    <= num_n;
      register_write     <= data_n;
      busy               <= busy_n;
      write_completed    <= wc_n;
      timeout_error      <= te_n;
      missed_count       <= missed_n;
    end
  end

  // NOTE: the snapshot is only read after a load, so it carries no reset and maps to plain storage.
  always_ff @(posedge s00_axi_aclk) begin
    if (load) begin
      for (int k = 0; k < REGISTERS_NUMBER; k++) begin
        shadow[k] <= values[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
